// File: rtl/edge_pkg.sv
// Shared types for the edge event bank: the per-channel edge mode encoding
// and the helper that decides whether a level change is reportable.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic logic edge_match(input edge_mode_e mode, input logic rising);
    case (mode)
      EDGE_RISE: return rising;
      EDGE_FALL: return !rising;
      EDGE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One input channel: synchroniser chain, optional debounce filter
// (EDGE_DEBOUNCE_EN), edge detect, one-cycle pulse and sticky pending flag.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STG = 2,
  parameter int DB_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  edge_mode_e mode,
  input  logic       clr,
  output logic       out,
  output logic       en,
  output logic       pend
);

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                lvl_q, lvl_d;
  logic                en_q, en_d;
  logic                pend_q, pend_d;
  logic                s;
  logic                change;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in;
    for (int i = 1; i < SYNC_STG; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STG-1];

`ifdef EDGE_DEBOUNCE_EN
  localparam int             DBW     = $clog2(DB_CYC) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

  logic [DBW-1:0] dbc_q, dbc_d;

  // The level only moves once s has disagreed with it for DB_CYC evaluations.
  always_comb begin
    dbc_d  = '0;
    change = 1'b0;
    if (s != lvl_q) begin
      if (dbc_q == DB_LAST) begin
        change = 1'b1;
      end else begin
        dbc_d = dbc_q + DB_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbc_q <= '0;
    end else begin
      dbc_q <= dbc_d;
    end
  end
`else
  // DB_CYC has no effect when the filter is compiled out.
  assign change = (s != lvl_q) && (DB_CYC >= 1);
`endif

  always_comb begin
    lvl_d  = change ? s : lvl_q;
    en_d   = change && edge_match(mode, s);
    pend_d = en_d || (pend_q && !clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      en_q   <= en_d;
      pend_q <= pend_d;
    end
  end

  assign out  = lvl_q;
  assign en   = en_q;
  assign pend = pend_q;

endmodule

// File: rtl/edge_event_bank.sv
// Bank of CH independent edge_chan instances plus the shared interrupt line.
// Debounce filtering is compiled in with EDGE_DEBOUNCE_EN.
module edge_event_bank
  import edge_pkg::*;
#(
  parameter int CH       = 4,
  parameter int SYNC_STG = 2,
  parameter int DB_CYC   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   out,
  output logic [CH-1:0]   en,
  output logic [CH-1:0]   pend,
  output logic            irq
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STG (SYNC_STG),
      .DB_CYC   (DB_CYC)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .in   (in[i]),
      .mode (edge_mode_e'(mode[2*i +: 2])),
      .clr  (clr[i]),
      .out  (out[i]),
      .en   (en[i]),
      .pend (pend[i])
    );
  end

  assign irq = |pend;

endmodule

// File: tb/tb_edge_event_bank.sv
// Self-checking bench for edge_event_bank: a vector table feeding a latency
// scoreboard, then hand sequences for clear, reset and mode corner cases.
module tb_edge_event_bank;
  import edge_pkg::*;

  localparam int CH       = 4;
  localparam int SYNC_STG = 2;
  localparam int DB_CYC   = 4;
`ifdef EDGE_DEBOUNCE_EN
  localparam int HOLD = DB_CYC;
  localparam int LAT  = SYNC_STG + DB_CYC;
`else
  localparam int HOLD = 1;
  localparam int LAT  = SYNC_STG + 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   in;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   out;
  logic [CH-1:0]   en;
  logic [CH-1:0]   pend;
  logic            irq;

  always #5 clk = ~clk;

  edge_event_bank #(
    .CH       (CH),
    .SYNC_STG (SYNC_STG),
    .DB_CYC   (DB_CYC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .mode (mode),
    .clr  (clr),
    .out  (out),
    .en   (en),
    .pend (pend),
    .irq  (irq)
  );

  typedef struct {
    logic [CH-1:0] in;
    logic [CH-1:0] expOut;
    logic [CH-1:0] expEn;
    logic [CH-1:0] expPend;
  } vec_t;

  typedef struct {
    int            due;
    logic [CH-1:0] expOut;
    logic [CH-1:0] expEn;
    logic [CH-1:0] expPend;
  } sb_t;

  vec_t vecs[8];
  sb_t  sbQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cyc         = 0;

  task automatic checkOutput(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) tick();
  endtask

  // Compare every scoreboard entry whose latency has elapsed.
  task automatic drainScoreboard();
    sb_t e;
    while (sbQ.size() > 0 && sbQ[0].due == cyc) begin
      e = sbQ.pop_front();
      checkOutput("tableOut", out, e.expOut);
      checkOutput("tableEn", en, e.expEn);
      checkOutput("tablePend", pend, e.expPend);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int h = 0; h < HOLD; h++) begin
      in = v.in;
      sbQ.push_back('{cyc + LAT, v.expOut, (h == 0) ? v.expEn : '0, v.expPend});
      tick();
      drainScoreboard();
    end
  endtask

  initial begin
    // ch0 RISE, ch1 FALL, ch2 BOTH, ch3 OFF
    vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b1111, 4'b1111, 4'b0101, 4'b0101};
    vecs[2] = '{4'b1111, 4'b1111, 4'b0000, 4'b0101};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0110, 4'b0111};
    vecs[4] = '{4'b1010, 4'b1010, 4'b0000, 4'b0111};
    vecs[5] = '{4'b0101, 4'b0101, 4'b0111, 4'b0111};
    vecs[6] = '{4'b0101, 4'b0101, 4'b0000, 4'b0111};
    vecs[7] = '{4'b1000, 4'b1000, 4'b0100, 4'b0111};

    rst  = 1'b1;
    in   = '0;
    clr  = '0;
    mode = '0;
    waitEdges(2);
    checkOutput("resetOut", out, 4'b0000);
    checkOutput("resetEn", en, 4'b0000);
    checkOutput("resetPend", pend, 4'b0000);
    checkOutput("resetIrq", CH'(irq), 4'b0000);
    rst = 1'b0;

    mode = 8'b00_11_10_01;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k]);
    end
    for (int k = 0; k < LAT; k++) begin
      tick();
      drainScoreboard();
    end
    testsRun++;
    if (sbQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboardDrain: got %0d entries left expected 0", sbQ.size());
    end

    // Clear coinciding with a new event: the set must win.
    mode = 8'hFF;
    in   = 4'b0000;
    waitEdges(LAT - 1);
    clr = 4'b1000;
    tick();
    checkOutput("setWinsEn", en, 4'b1000);
    checkOutput("setWinsPend", pend, 4'b1111);
    clr = 4'b0001;
    tick();
    checkOutput("clrOneEn", en, 4'b0000);
    checkOutput("clrOnePend", pend, 4'b1110);
    checkOutput("clrOneIrq", CH'(irq), 4'b0001);
    clr = 4'b1110;
    tick();
    checkOutput("clrRestPend", pend, 4'b0000);
    checkOutput("clrRestIrq", CH'(irq), 4'b0000);
    clr = '0;

    // Reset with pend set and an edge in flight.
    in = 4'b1010;
    waitEdges(LAT);
    checkOutput("preResetEn", en, 4'b1010);
    checkOutput("preResetPend", pend, 4'b1010);
    in = 4'b1111;
    waitEdges(2);
    checkOutput("inFlightOut", out, 4'b1010);
    rst = 1'b1;
    tick();
    checkOutput("midResetOut", out, 4'b0000);
    checkOutput("midResetEn", en, 4'b0000);
    checkOutput("midResetPend", pend, 4'b0000);
    checkOutput("midResetIrq", CH'(irq), 4'b0000);
    rst = 1'b0;
    waitEdges(LAT - 1);
    checkOutput("postResetEarlyOut", out, 4'b0000);
    checkOutput("postResetEarlyEn", en, 4'b0000);
    tick();
    checkOutput("postResetOut", out, 4'b1111);
    checkOutput("postResetEn", en, 4'b1111);
    checkOutput("postResetPend", pend, 4'b1111);
    tick();
    checkOutput("pulseWidthEn", en, 4'b0000);

    // EDGE_OFF tracks the level without raising events.
    mode = 8'h00;
    clr  = 4'b1111;
    tick();
    clr = '0;
    checkOutput("offClrPend", pend, 4'b0000);
    for (int j = 0; j < 3; j++) begin
      in = ~in;
      waitEdges(LAT);
      checkOutput("offOut", out, in);
      checkOutput("offEn", en, 4'b0000);
      checkOutput("offPend", pend, 4'b0000);
    end
    mode = 8'hFF;
    in   = ~in;
    waitEdges(LAT);
    checkOutput("bothEn", en, 4'b1111);
    checkOutput("bothPend", pend, 4'b1111);
    checkOutput("bothIrq", CH'(irq), 4'b0001);

`ifndef EDGE_DEBOUNCE_EN
    // Opposite edges on consecutive cycles give consecutive pulses.
    in = 4'b0000;
    tick();
    in = 4'b1111;
    waitEdges(LAT - 1);
    checkOutput("b2bFallEn", en, 4'b1111);
    checkOutput("b2bFallOut", out, 4'b0000);
    tick();
    checkOutput("b2bRiseEn", en, 4'b1111);
    checkOutput("b2bRiseOut", out, 4'b1111);
`else
    // A low glitch one cycle shorter than DB_CYC must be filtered out.
    in = 4'b1011;
    waitEdges(DB_CYC - 1);
    in = 4'b1111;
    for (int j = 0; j < LAT + 2; j++) begin
      tick();
      checkOutput("glitchEn", en, 4'b0000);
      checkOutput("glitchOut", out, 4'b1111);
    end
    in = 4'b1011;
    waitEdges(LAT - 1);
    checkOutput("dbEarlyOut", out, 4'b1111);
    tick();
    checkOutput("dbEn", en, 4'b0100);
    checkOutput("dbOut", out, 4'b1011);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/edge_event_bank.md
# edge_event_bank

Multi-channel synchroniser and edge-event detector for asynchronous control inputs such as ADC busy/DRDY lines, DAC LDAC feedback and external triggers. Each channel passes its input through a configurable synchroniser chain and an optional debounce filter, then detects edges per a runtime-selected mode. Detected edges produce a one-cycle pulse and a sticky pending flag; flags are cleared write-1-to-clear. Sits between the pad inputs and the converter driver FSMs and interrupt logic.

## Interface
- CH, 4: number of channels, ≥1
- SYNC_STG, 2: synchroniser flops per channel, ≥1
- DB_CYC, 4: debounce stability length in cycles, ≥1; ignored without the debounce macro
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in  input  CH  asynchronous raw inputs
- mode  input  2*CH  per-channel edge mode, channel i at [2i+1:2i], type edge_mode_e
- clr  input  CH  write-1-to-clear for pend
- out  output  CH  filtered, synchronised level
- en  output  CH  one-cycle edge pulse
- pend  output  CH  sticky edge flags
- irq  output  1  OR of pend

## Operation
- Per channel: sync chain sync[0..SYNC_STG-1] ← in; s = sync[SYNC_STG-1]; registered level lvl drives out.
- Modes: EDGE_OFF=00 no events; EDGE_RISE=01 lvl 0→1; EDGE_FALL=10 lvl 1→0; EDGE_BOTH=11 either.
- lvl update without debounce: lvl ← s every cycle; en ← (s≠lvl) & mode match, registered, same edge as lvl.
- Debounce: counter dbc, width $clog2(DB_CYC)+1. If s==lvl, dbc ← 0. If s≠lvl and dbc==DB_CYC-1, lvl ← s, en fires, dbc ← 0. Else dbc ← dbc+1. Glitches shorter than DB_CYC cycles at s never reach lvl.
- pend[i] ← 1 on en[i]; cleared by clr[i]=1. Simultaneous en and clr: set wins.
- mode is sampled each cycle and applies to the edge evaluated at that edge; EDGE_OFF still tracks out and leaves pend untouched.
- Channels fully independent; no cross-channel priority.
- irq combinational OR of pend.

## Timing
- Reset values: sync chain 0, lvl/out 0, dbc 0, en 0, pend 0, irq 0.
- Input held high through reset: a rising edge is reported after reset release (level 0→1), as for any other edge.
- Reset asserted mid-debounce or with pend set: all state returns to reset values on that edge; in-flight edge discarded.
- Latency, without debounce: out/en change SYNC_STG+1 rising edges after the first edge sampling the new input.
- Latency, with debounce: SYNC_STG+DB_CYC edges; DB_CYC=1 equals the non-debounced timing.
- en is exactly one cycle wide; back-to-back opposite edges in EDGE_BOTH give pulses on consecutive cycles when the input permits.
- clr takes effect on the next edge; pend low the cycle after.

## Configuration
- EDGE_DEBOUNCE_EN defined: debounce counter per channel as described, DB_CYC honoured.
- Not defined: no dbc registers; lvl ← s every cycle; DB_CYC ignored; latency SYNC_STG+1.

## Structure
- Package edge_pkg: typedef enum logic [1:0] edge_mode_e {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
- Sub-module edge_chan: one channel (sync, optional debounce, detect, pend); top generates CH instances and forms irq.

## Test plan
- CH=4, SYNC_STG=2, no macro, mode[1:0]=EDGE_RISE; in[0] 0→1 → en[0] pulses 1 cycle at edge 3, out[0]=1, pend[0]=1, irq=1.
- Same, mode=EDGE_FALL, in[1] 1→0 after settling → one en[1] pulse; rising edge on in[1] → no pulse, pend[1] unchanged.
- EDGE_DEBOUNCE_EN, DB_CYC=4: in[2] high for 3 cycles then low → no en, out[2] stays 0; high for 4 cycles → en[2] at edge 6.
- pend[3]=1, clr[3]=1 on the same cycle as a new en[3] → pend[3] stays 1; clr alone → pend[3]=0, irq=0 next cycle.
- Reset asserted with dbc mid-count and pend=4'b1010 → all outputs 0 next edge; in held high → rising event reported SYNC_STG+DB_CYC edges after release.
- mode=EDGE_OFF with in toggling → out tracks, en and pend stay 0; switch to EDGE_BOTH → every subsequent edge pulses.
